// File: rtl/image_encoder.sv
// Serial camera-link frame encoder: sync codes on cam_sync, four 16-bit pixel lanes on cam_data.
// States: IDLE wait | FS/LS/IMG/LE/FE code bits | GAP_* idle gaps | DATA pixel words.
module image_encoder #(
  parameter int LINES = 4,
  parameter int WORDS = 8,
  parameter int GAP   = 4
) (
  input  logic        cam_out_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [63:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        cam_sync,
  output logic [3:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FS     = 4'd1;
  localparam logic [3:0] S_GAP_FS = 4'd2;
  localparam logic [3:0] S_LS     = 4'd3;
  localparam logic [3:0] S_GAP_LS = 4'd4;
  localparam logic [3:0] S_IMG    = 4'd5;
  localparam logic [3:0] S_DATA   = 4'd6;
  localparam logic [3:0] S_LE     = 4'd7;
  localparam logic [3:0] S_GAP_LE = 4'd8;
  localparam logic [3:0] S_FE     = 4'd9;

  localparam logic [7:0] CODE_FS  = 8'hAA;
  localparam logic [7:0] CODE_LS  = 8'h2A;
  localparam logic [7:0] CODE_IMG = 8'h0D;
  localparam logic [7:0] CODE_LE  = 8'h4A;
  localparam logic [7:0] CODE_FE  = 8'hCA;

  localparam logic [7:0]  GAP_LAST  = 8'(GAP - 1);
  localparam logic [15:0] WORD_LAST = 16'(WORDS - 1);
  localparam logic [15:0] LINE_LAST = 16'(LINES - 1);

  logic [3:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] word_q, word_d;
  logic [15:0] line_q, line_d;
  logic [63:0] sreg_q, sreg_d;
  logic        sync_q, sync_d;
  logic [3:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        uf_q, uf_d;
  logic        take;
  logic [7:0]  code_sel;

  // A word is consumed on IMG bit 0 and on the LSB of every word but the last.
  assign take = (state_q == S_IMG && cnt_q == 8'd0) ||
                (state_q == S_DATA && bit_q == 4'd15 && word_q != WORD_LAST);

  assign pix_ready = take & reset_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    line_d  = line_q;
    sreg_d  = sreg_q;
    uf_d    = uf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_FS;
          cnt_d   = 8'd7;
          bit_d   = 4'd0;
          word_d  = 16'd0;
          line_d  = 16'd0;
          uf_d    = 1'b0;
        end
      end
      S_FS: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP_FS;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP_FS: begin
        if (cnt_q == 8'd0) begin
          state_d = S_LS;
          cnt_d   = 8'd7;
          word_d  = 16'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LS: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP_LS;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP_LS: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IMG;
          cnt_d   = 8'd7;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_IMG: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DATA;
          bit_d   = 4'd0;
          word_d  = 16'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DATA: begin
        bit_d = bit_q + 4'd1;
        for (int i = 0; i < 4; i++) begin
          sreg_d[16*i +: 16] = {sreg_q[16*i +: 15], 1'b0};
        end
        if (bit_q == 4'd15) begin
          if (word_q == WORD_LAST) begin
            state_d = S_LE;
            cnt_d   = 8'd7;
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      S_LE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP_LE;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP_LE: begin
        if (cnt_q == 8'd0) begin
          cnt_d = 8'd7;
          if (line_q == LINE_LAST) begin
            state_d = S_FE;
          end else begin
            state_d = S_LS;
            line_d  = line_q + 16'd1;
            word_d  = 16'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_FE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A missing word is replaced by zeros so the line keeps its length.
    if (take) begin
      sreg_d = pix_valid ? pix_data : 64'h0;
      if (!pix_valid) uf_d = 1'b1;
    end
  end

  always_comb begin
    case (state_d)
      S_FS:    code_sel = CODE_FS;
      S_LS:    code_sel = CODE_LS;
      S_IMG:   code_sel = CODE_IMG;
      S_LE:    code_sel = CODE_LE;
      S_FE:    code_sel = CODE_FE;
      default: code_sel = 8'h00;
    endcase
    sync_d = code_sel[cnt_d[2:0]];
    data_d = (state_d == S_DATA) ? {sreg_d[63], sreg_d[47], sreg_d[31], sreg_d[15]} : 4'h0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge cam_out_clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      word_q  <= 16'd0;
      line_q  <= 16'd0;
      sreg_q  <= 64'h0;
      sync_q  <= 1'b0;
      data_q  <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      line_q  <= line_d;
      sreg_q  <= sreg_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      uf_q    <= uf_d;
    end
  end

  assign cam_sync   = sync_q;
  assign cam_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_image_encoder.sv
// Scoreboard bench: expected per-cycle line activity is built from the frame format rules and
// compared cycle by cycle against the encoder outputs.
module tb_image_encoder;

  localparam int L  = 2;
  localparam int W  = 2;
  localparam int G  = 3;
  localparam int F1 = 8 + G + L * (8 + G + 8 + 16 * W + 8 + G) + 8 + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [63:0] pix_data;
  logic        pix_valid;
  logic        pix_ready, cam_sync, busy, frame_done, underflow;
  logic [3:0]  cam_data;

  image_encoder #(.LINES(L), .WORDS(W), .GAP(G)) dut (
    .cam_out_clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cam_sync(cam_sync), .cam_data(cam_data), .busy(busy),
    .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [63:0] words [512];
  logic        vld   [512];
  logic [7:0]  exp_q [$];
  int          checks = 0, errors = 0;
  int          drv_idx = 0, model_idx = 0, ready_cnt = 0;
  logic        uf_model = 1'b0;
  logic        mon_en = 1'b0;

  // Source: presents word drv_idx until the encoder takes it.
  always begin
    @(negedge clk);
    if (pix_ready === 1'b1) begin
      ready_cnt++;
      @(posedge clk);
      #1;
      drv_idx++;
      pix_data  = words[drv_idx & 511];
      pix_valid = vld[drv_idx & 511];
    end
  end

  // Monitor: every cycle is either an expected stream entry or must look idle.
  always @(negedge clk) begin
    logic [7:0] e, act;
    if (mon_en) begin
      act = {cam_sync, cam_data, busy, frame_done, underflow};
      checks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL stream @%0t: got %b want %b (sync,data,busy,done,uf)", $time, act, e);
        end
      end else if ({pix_ready, act} !== {1'b0, 6'b0, uf_model}) begin
        errors++;
        $display("FAIL idle @%0t: got rdy=%b %b want rdy=0 %b", $time, pix_ready, act,
                 {6'b0, uf_model});
      end
    end
  end

  task automatic push(input logic s, input logic [3:0] d, input logic b, input logic dn,
                      input logic u);
    exp_q.push_back({s, d, b, dn, u});
  endtask

  task automatic push_code(input logic [7:0] c, input logic u);
    for (int b = 7; b >= 0; b--) push(c[b], 4'h0, 1'b1, 1'b0, u);
  endtask

  task automatic push_gap(input logic u);
    for (int i = 0; i < G; i++) push(1'b0, 4'h0, 1'b1, 1'b0, u);
  endtask

  task automatic push_frame();
    logic        u;
    logic [63:0] wd;
    u = 1'b0;
    push_code(8'hAA, u);
    push_gap(u);
    for (int l = 0; l < L; l++) begin
      push_code(8'h2A, u);
      push_gap(u);
      push_code(8'h0D, u);
      for (int w = 0; w < W; w++) begin
        wd = words[model_idx & 511];
        if (!vld[model_idx & 511]) begin
          wd = 64'h0;
          u  = 1'b1;
        end
        model_idx++;
        for (int b = 15; b >= 0; b--)
          push(1'b0, {wd[48+b], wd[32+b], wd[16+b], wd[b]}, 1'b1, 1'b0, u);
      end
      push_code(8'h4A, u);
      push_gap(u);
    end
    push_code(8'hCA, u);
    push(1'b0, 4'h0, 1'b0, 1'b1, u);
    uf_model = u;
  endtask

  task automatic accept();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    push_frame();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 4 * F1) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_eq(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  initial begin
    int r0, n;
    for (int i = 0; i < 512; i++) begin
      words[i] = {$urandom, $urandom};
      vld[i]   = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) vld[i] = 1'b1;
    vld[5]    = 1'b0;  // second word of a line in the second frame
    pix_data  = words[0];
    pix_valid = vld[0];

    repeat (3) @(posedge clk);
    #1;
    check_eq("ready_in_reset", int'(pix_ready), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);

    // Frame A: all words valid.
    r0 = ready_cnt;
    accept();
    frame_start = 1'b0;
    wait_empty("frame_a");
    check_eq("ready_count_a", ready_cnt - r0, L * W);
    check_eq("uf_clear_a", int'(underflow), 0);

    // Frame B: second word of line 0 missing.
    r0 = ready_cnt;
    accept();
    frame_start = 1'b0;
    wait_empty("frame_b");
    check_eq("ready_count_b", ready_cnt - r0, L * W);
    check_eq("uf_sticky_b", int'(underflow), 1);

    // Frame C: random gaps in pix_valid, stray starts mid-frame and on the FE end edge.
    r0 = ready_cnt;
    accept();
    n = 0;
    while (exp_q.size() > 0 && n < 4 * F1) begin
      if (exp_q.size() == 2) frame_start = 1'b1;
      else if (exp_q.size() > 2) frame_start = ($urandom_range(0, 9) == 0);
      else frame_start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    frame_start = 1'b0;
    wait_empty("frame_c");
    check_eq("ready_count_c", ready_cnt - r0, L * W);

    // Back-to-back: frame_start held high over three frames.
    r0 = ready_cnt;
    accept();
    push_frame();
    push_frame();
    n = 0;
    while (exp_q.size() > F1 - 5 && n < 8 * F1) begin
      @(negedge clk);
      n++;
    end
    frame_start = 1'b0;
    wait_empty("back_to_back");
    check_eq("ready_count_b2b", ready_cnt - r0, 3 * L * W);

    // Reset during DATA of line 0, then a fresh frame.
    accept();
    frame_start = 1'b0;
    n = 0;
    while (exp_q.size() > F1 - 40 && n < 2 * F1) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    uf_model = 1'b0;
    @(negedge clk);
    check_eq("ready_during_reset", int'(pix_ready), 0);
    check_eq("busy_after_reset", int'(busy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_idx = drv_idx;
    repeat (3) @(negedge clk);
    r0 = ready_cnt;
    accept();
    frame_start = 1'b0;
    wait_empty("after_reset");
    check_eq("ready_count_rst", ready_cnt - r0, L * W);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
